// File: rtl/fastram_sdram_if.sv
// fastram_sdram_if: bundle of the core-side fast-RAM port and the SDRAM controller port.
//   slave  - the bridge's view (core signals in, SDRAM request out)
//   master - the environment's view (core plus SDRAM controller)
// Core side : fast_clk, fastram_ce, fastram_we, fastram_address, fastram_datatoram,
//             fastram_datafromram, cpu_wait
// SDRAM side: sdram_req, sdram_we, sdram_addr, sdram_din, sdram_dout, sdram_ack, timeout_err
interface fastram_sdram_if #(
  parameter int unsigned ADDR_W = 23
) ();
  logic              fast_clk;
  logic              fastram_ce;
  logic              fastram_we;
  logic [ADDR_W-1:0] fastram_address;
  logic [7:0]        fastram_datatoram;
  logic [7:0]        fastram_datafromram;
  logic              cpu_wait;
  logic              sdram_req;
  logic              sdram_we;
  logic [ADDR_W-1:0] sdram_addr;
  logic [7:0]        sdram_din;
  logic [7:0]        sdram_dout;
  logic              sdram_ack;
  logic              timeout_err;

  modport slave (
    input  fast_clk, fastram_ce, fastram_we, fastram_address, fastram_datatoram,
    input  sdram_dout, sdram_ack,
    output fastram_datafromram, cpu_wait,
    output sdram_req, sdram_we, sdram_addr, sdram_din, timeout_err
  );

  modport master (
    output fast_clk, fastram_ce, fastram_we, fastram_address, fastram_datatoram,
    output sdram_dout, sdram_ack,
    input  fastram_datafromram, cpu_wait,
    input  sdram_req, sdram_we, sdram_addr, sdram_din, timeout_err
  );
endinterface

// File: rtl/fastram_sdram_bridge.sv
// fastram_sdram_bridge: turns per-CPU-slot fast-RAM accesses into an SDRAM req/ack handshake.
// One-entry posted write buffer with read-after-write forwarding, a held read-data register,
// cpu_wait stall generation and a request timeout with a sticky error flag.
// Ports:
//   clk_sys - system clock
//   reset   - asynchronous active-high reset
//   bus_io  - fastram_sdram_if.slave: core access port and SDRAM controller request port
module fastram_sdram_bridge #(
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned TIMEOUT = 64
) (
  input logic            clk_sys,
  input logic            reset,
  fastram_sdram_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StWrDrain, StRdIssue, StRdWait} state_e;

  localparam int unsigned     CntW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [7:0]        wb_data_q, wb_data_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              wait_q, wait_d;
  logic              terr_q, terr_d;
  logic [CntW-1:0]   tcnt_q, tcnt_d;

  logic acc, ack, expire, hit;

  always_comb begin
    // A stalled access is re-sampled every cycle; the core holds its inputs meanwhile.
    acc    = (bus_io.fast_clk & bus_io.fastram_ce) | wait_q;
    ack    = bus_io.sdram_ack & req_q;
    expire = req_q & ~ack & (tcnt_q == CntLast);
    hit    = wb_valid_q & (bus_io.fastram_address == wb_addr_q);
  end

  always_comb begin
    state_d    = state_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    rdata_d    = rdata_q;
    wait_d     = wait_q;
    terr_d     = terr_q;
    tcnt_d     = (req_q && !ack && !expire) ? tcnt_q + 1'b1 : '0;

    unique case (state_q)
      StIdle: begin
        if (acc) begin
          if (bus_io.fastram_we) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = bus_io.fastram_address;
            wb_data_d  = bus_io.fastram_datatoram;
            req_d      = 1'b1;
            we_d       = 1'b1;
            addr_d     = bus_io.fastram_address;
            din_d      = bus_io.fastram_datatoram;
            wait_d     = 1'b0;
            state_d    = StWrDrain;
          end else begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = bus_io.fastram_address;
            wait_d  = 1'b1;
            state_d = StRdWait;
          end
        end
      end

      StWrDrain: begin
        if (ack) begin
          wb_valid_d = 1'b0;
          req_d      = 1'b0;
          state_d    = StIdle;
          if (acc && bus_io.fastram_we) begin
            // Refill the buffer on the retiring write's ack; req re-arms after a one-cycle gap.
            wb_valid_d = 1'b1;
            wb_addr_d  = bus_io.fastram_address;
            wb_data_d  = bus_io.fastram_datatoram;
            addr_d     = bus_io.fastram_address;
            din_d      = bus_io.fastram_datatoram;
            wait_d     = 1'b0;
            state_d    = StWrDrain;
          end else if (acc && hit) begin
            rdata_d = wb_data_q;
          end else if (acc) begin
            wait_d  = 1'b1;
            state_d = StRdIssue;
          end
        end else if (expire) begin
          // Posted write is dropped; a pending access is retried from idle.
          wb_valid_d = 1'b0;
          req_d      = 1'b0;
          terr_d     = 1'b1;
          state_d    = StIdle;
          if (acc) begin
            wait_d = 1'b1;
          end
        end else begin
          if (!req_q) begin
            req_d = 1'b1;
            we_d  = 1'b1;
          end
          if (acc) begin
            if (bus_io.fastram_we || !hit) begin
              wait_d = 1'b1;
            end else begin
              rdata_d = wb_data_q;
            end
          end
        end
      end

      StRdIssue: begin
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = bus_io.fastram_address;
        state_d = StRdWait;
      end

      StRdWait: begin
        if (ack) begin
          rdata_d = bus_io.sdram_dout;
          req_d   = 1'b0;
          wait_d  = 1'b0;
          state_d = StIdle;
        end else if (expire) begin
          rdata_d = 8'hFF;
          req_d   = 1'b0;
          wait_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      rdata_q    <= 8'hFF;
      wait_q     <= 1'b0;
      terr_q     <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rdata_q    <= rdata_d;
      wait_q     <= wait_d;
      terr_q     <= terr_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign bus_io.fastram_datafromram = rdata_q;
  assign bus_io.cpu_wait            = wait_q;
  assign bus_io.sdram_req           = req_q;
  assign bus_io.sdram_we            = we_q;
  assign bus_io.sdram_addr          = addr_q;
  assign bus_io.sdram_din           = din_q;
  assign bus_io.timeout_err         = terr_q;

endmodule

// File: tb/tb_fastram_sdram_bridge.sv
// tb_fastram_sdram_bridge: directed scenarios plus randomized core traffic against a memory-level
// model. The SDRAM responder checks request order, contents and stability; a compare process
// checks the held read data and error flag every cycle.
module tb_fastram_sdram_bridge;

  typedef struct {
    logic        we;
    logic [22:0] addr;
    logic [7:0]  data;
    logic        fwd_ok;
  } txn_t;

  logic clk_sys = 1'b0;
  logic reset;

  fastram_sdram_if #(.ADDR_W(23)) bus ();

  fastram_sdram_bridge #(.ADDR_W(23), .TIMEOUT(64)) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus_io (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [7:0]  core_mem  [logic [22:0]];
  logic [7:0]  sdram_mem [logic [22:0]];
  txn_t        exp_q[$];
  logic        have_wr = 1'b0;
  logic [22:0] last_wr_addr = '0;
  logic [7:0]  pend_rd = 8'h00;
  logic [7:0]  exp_rdata = 8'hFF;
  logic        exp_terr = 1'b0;
  logic        chk_en = 1'b0;

  // Responder state
  logic        resp_en = 1'b1;
  logic        rand_lat = 1'b0;
  logic        stray_ack = 1'b0;
  int          lat = 0;
  int          req_count = 0;
  int          last_req_len = 0;
  logic        log_we[$];
  logic [22:0] log_addr[$];
  logic [7:0]  log_din[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [22:0] a);
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h3C;
  endfunction

  // fast_clk: one clk_sys cycle in eight
  initial begin
    int phase;
    phase = 0;
    bus.fast_clk = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      phase = (phase + 1) % 8;
      bus.fast_clk = (phase == 7);
    end
  end

  // SDRAM controller model
  initial begin
    logic        in_flight, acked, cur_we;
    logic [22:0] cur_addr;
    logic [7:0]  cur_din;
    int          cnt;
    txn_t        t;
    in_flight = 1'b0; acked = 1'b0; cnt = 0;
    cur_we = 1'b0; cur_addr = '0; cur_din = '0;
    bus.sdram_ack  = 1'b0;
    bus.sdram_dout = 8'h00;
    forever begin
      @(posedge clk_sys); #1;
      bus.sdram_ack = stray_ack;
      if (bus.sdram_req && !reset) begin
        if (!in_flight) begin
          in_flight = 1'b1; acked = 1'b0; cnt = 0;
          cur_we = bus.sdram_we; cur_addr = bus.sdram_addr; cur_din = bus.sdram_din;
          req_count++;
          log_we.push_back(cur_we); log_addr.push_back(cur_addr); log_din.push_back(cur_din);
          if (rand_lat) lat = $urandom_range(0, 20);
          while (exp_q.size() > 0 && exp_q[0].fwd_ok &&
                 !(exp_q[0].we == cur_we && exp_q[0].addr == cur_addr))
            void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL req_unexpected: got we=%0b addr=%0h expected none", cur_we, cur_addr);
          end else begin
            t = exp_q.pop_front();
            check("req_we", 32'(cur_we), 32'(t.we));
            check("req_addr", 32'(cur_addr), 32'(t.addr));
            if (t.we) check("req_din", 32'(cur_din), 32'(t.data));
          end
        end else begin
          cnt++;
          if (acked) begin
            total++; bad++;
            $display("FAIL req_after_ack: got req=1 expected 0 at %0t", $time);
          end
          check("req_stable_we", 32'(bus.sdram_we), 32'(cur_we));
          check("req_stable_addr", 32'(bus.sdram_addr), 32'(cur_addr));
          if (cur_we) check("req_stable_din", 32'(bus.sdram_din), 32'(cur_din));
        end
        if (resp_en && !acked && cnt >= lat) begin
          bus.sdram_ack = 1'b1;
          acked = 1'b1;
          if (cur_we) begin
            sdram_mem[cur_addr] = cur_din;
          end else begin
            bus.sdram_dout = sdram_mem.exists(cur_addr) ? sdram_mem[cur_addr] : dflt(cur_addr);
          end
        end
      end else begin
        if (in_flight) last_req_len = cnt + 1;
        in_flight = 1'b0;
      end
    end
  end

  // Every-cycle compare of the held read data and the sticky error flag
  initial begin
    forever begin
      @(negedge clk_sys);
      if (chk_en) begin
        check("rdata_hold", 32'(bus.fastram_datafromram), 32'(exp_rdata));
        check("timeout_err", 32'(bus.timeout_err), 32'(exp_terr));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic core_start(input logic we, input logic [22:0] a, input logic [7:0] d);
    txn_t t;
    @(negedge clk_sys);
    while (!bus.fast_clk) @(negedge clk_sys);
    bus.fastram_ce = 1'b1; bus.fastram_we = we;
    bus.fastram_address = a; bus.fastram_datatoram = d;
    t.we = we; t.addr = a; t.data = we ? d : 8'h00;
    t.fwd_ok = !we && have_wr && (a == last_wr_addr);
    exp_q.push_back(t);
    if (we) begin
      core_mem[a] = d; have_wr = 1'b1; last_wr_addr = a;
    end else begin
      pend_rd = core_mem.exists(a) ? core_mem[a] : dflt(a);
    end
    @(posedge clk_sys); #2;
  endtask

  task automatic core_finish(input logic we, input logic abort, output int wc);
    wc = 0;
    while (bus.cpu_wait && wc < 400) begin
      wc++;
      @(posedge clk_sys); #2;
    end
    if (wc >= 400) check("cpu_wait_bound", 32'(wc), 32'd0);
    bus.fastram_ce = 1'b0;
    if (!we) exp_rdata = abort ? 8'hFF : pend_rd;
  endtask

  task automatic core_access(input logic we, input logic [22:0] a, input logic [7:0] d,
                             input logic abort, output int wc);
    core_start(we, a, d);
    core_finish(we, abort, wc);
  endtask

  task automatic settle();
    int g;
    g = 0;
    @(posedge clk_sys); #2;
    while ((bus.sdram_req || bus.cpu_wait) && g < 300) begin
      @(posedge clk_sys); #2;
      g++;
    end
    if (g >= 300) check("settle_bound", 32'(g), 32'd0);
    repeat (2) @(posedge clk_sys);
    #2;
  endtask

  initial begin
    int wc, wc2, rc0, n;
    reset = 1'b1;
    bus.fastram_ce = 1'b0; bus.fastram_we = 1'b0;
    bus.fastram_address = '0; bus.fastram_datatoram = '0;
    #1;
    check("rst_rdata", 32'(bus.fastram_datafromram), 32'hFF);
    check("rst_req", 32'(bus.sdram_req), 32'd0);
    check("rst_wait", 32'(bus.cpu_wait), 32'd0);
    check("rst_terr", 32'(bus.timeout_err), 32'd0);
    check("rst_we_addr_din", 32'({bus.sdram_we, bus.sdram_addr, bus.sdram_din}), 32'd0);
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    chk_en = 1'b1;

    // 1. posted write, ack latency 3
    lat = 3; rc0 = req_count;
    core_access(1'b1, 23'h012345, 8'h5A, 1'b0, wc);
    check("t1_no_wait", 32'(wc), 32'd0);
    settle();
    check("t1_req_count", 32'(req_count - rc0), 32'd1);
    check("t1_log", 32'({log_we[log_we.size()-1], log_addr[log_addr.size()-1],
                         log_din[log_din.size()-1]}), 32'({1'b1, 23'h012345, 8'h5A}));
    check("t1_req_len", 32'(last_req_len), 32'd4);

    // 2. read-after-write forwarded from the buffer
    lat = 20; rc0 = req_count;
    core_access(1'b1, 23'h000100, 8'h11, 1'b0, wc);
    core_access(1'b0, 23'h000100, 8'h00, 1'b0, wc2);
    check("t2_wr_wait", 32'(wc), 32'd0);
    check("t2_rd_wait", 32'(wc2), 32'd0);
    check("t2_fwd_data", 32'(bus.fastram_datafromram), 32'h11);
    settle();
    check("t2_req_count", 32'(req_count - rc0), 32'd1);

    // 3. read miss, ack latency 5
    lat = 5;
    sdram_mem[23'h7F0000] = 8'hC3; core_mem[23'h7F0000] = 8'hC3;
    core_access(1'b0, 23'h7F0000, 8'h00, 1'b0, wc);
    check("t3_wait_cycles", 32'(wc), 32'd6);
    repeat (10) @(posedge clk_sys);
    #2;
    check("t3_held_data", 32'(bus.fastram_datafromram), 32'hC3);

    // 4. read miss behind a pending write: write drains first
    lat = 12;
    core_access(1'b1, 23'h000200, 8'h42, 1'b0, wc);
    core_access(1'b0, 23'h000300, 8'h00, 1'b0, wc2);
    check("t4_rd_wait", 32'(wc2), 32'd19);
    check("t4_first_wr", 32'({log_we[log_we.size()-2], log_addr[log_addr.size()-2]}),
          32'({1'b1, 23'h000200}));
    check("t4_then_rd", 32'({log_we[log_we.size()-1], log_addr[log_addr.size()-1]}),
          32'({1'b0, 23'h000300}));
    settle();

    // Randomized traffic over a small address pool to provoke hits, stalls and refills
    rand_lat = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic        rwe;
      logic [22:0] ra;
      logic [7:0]  rd;
      rwe = 1'($urandom_range(0, 1));
      ra  = 23'h040000 + 23'($urandom_range(0, 5) << 4);
      rd  = 8'($urandom);
      repeat ($urandom_range(0, 12)) @(posedge clk_sys);
      core_access(rwe, ra, rd, 1'b0, wc);
    end
    settle();
    rand_lat = 1'b0;

    // 5. read that never gets an ack
    resp_en = 1'b0;
    core_access(1'b0, 23'h001234, 8'h00, 1'b1, wc);
    exp_terr = 1'b1;
    check("t5_wait_cycles", 32'(wc), 32'd64);
    check("t5_abort_data", 32'(bus.fastram_datafromram), 32'hFF);
    check("t5_terr", 32'(bus.timeout_err), 32'd1);
    @(posedge clk_sys); #2;
    check("t5_req_len", 32'(last_req_len), 32'd64);
    check("t5_req_low", 32'(bus.sdram_req), 32'd0);

    // 6. reset while waiting on a read
    core_start(1'b0, 23'h000400, 8'h00);
    repeat (3) @(posedge clk_sys);
    #2;
    check("t6_pre_req", 32'(bus.sdram_req), 32'd1);
    check("t6_pre_wait", 32'(bus.cpu_wait), 32'd1);
    #1;
    reset = 1'b1; exp_rdata = 8'hFF; exp_terr = 1'b0;
    #1;
    check("t6_async_req", 32'(bus.sdram_req), 32'd0);
    check("t6_async_wait", 32'(bus.cpu_wait), 32'd0);
    bus.fastram_ce = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    rc0 = req_count; n = log_we.size();
    stray_ack = 1'b1;
    @(posedge clk_sys); #2;
    stray_ack = 1'b0;
    repeat (2) @(posedge clk_sys);
    #2;
    check("t6_stray_req", 32'(bus.sdram_req), 32'd0);
    check("t6_stray_wait", 32'(bus.cpu_wait), 32'd0);
    check("t6_stray_data", 32'(bus.fastram_datafromram), 32'hFF);
    resp_en = 1'b1; lat = 2;
    core_access(1'b1, 23'h000500, 8'h77, 1'b0, wc);
    check("t6_wr_no_wait", 32'(wc), 32'd0);
    settle();
    check("t6_req_count", 32'(req_count - rc0), 32'd1);
    check("t6_log_size", 32'(log_we.size() - n), 32'd1);
    check("t6_log", 32'({log_we[log_we.size()-1], log_addr[log_addr.size()-1],
                         log_din[log_din.size()-1]}), 32'({1'b1, 23'h000500, 8'h77}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
